// File: rtl/dev_tx_hex_pkg.sv
// Shared definitions for the hex print formatter: ASCII constants, nibble mapping, FSM states.
package pkg_hex;

    import pkg_ram::*;

    localparam int unsigned HEX_DIGITS = 16;

    localparam logic [RAM_BYTE-1:0] ASCII_0  = 8'h30;
    localparam logic [RAM_BYTE-1:0] ASCII_x  = 8'h78;
    localparam logic [RAM_BYTE-1:0] ASCII_NL = 8'h0A;
    localparam logic [RAM_BYTE-1:0] ASCII_UA = 8'h41;
    localparam logic [RAM_BYTE-1:0] ASCII_LA = 8'h61;

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        GAP
    } hex_state_t;

    function automatic logic [RAM_BYTE-1:0] nibble_to_ascii(input logic [3:0] nibble,
                                                             input logic       upper);
        if (nibble < 4'd10)
            return ASCII_0 + RAM_BYTE'(nibble);
        else
            return (upper ? ASCII_UA : ASCII_LA) + RAM_BYTE'(nibble - 4'd10);
    endfunction

endpackage

// File: rtl/pkg_ram.sv
// Memory/transmit-path shared sizing.
package pkg_ram;

    localparam int unsigned RAM_BYTE = 8;

endpackage

// File: rtl/dev_tx_hex.sv
// Hex print formatter: latches a word on start and pushes its ASCII hex form into the TX FIFO,
// one byte every two cycles so each push decision sees a settled full flag.
module dev_tx_hex
    import pkg_ram::*;
    import pkg_hex::*;
#(
    parameter int unsigned WORD_BITS = 64,
    parameter int unsigned PREFIX    = 1,
    parameter int unsigned NEWLINE   = 1,
    parameter int unsigned UPPER     = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WORD_BITS-1:0] value,
    input  logic [3:0]           digits,
    output logic                 busy,
    output logic                 done,
    output logic                 push_back,
    output logic [RAM_BYTE-1:0]  data_out,
    input  logic                 full
);

    localparam logic [4:0] PRE_LEN = (PREFIX  != 0) ? 5'd2 : 5'd0;
    localparam logic [4:0] NL_LEN  = (NEWLINE != 0) ? 5'd1 : 5'd0;

    hex_state_t           state;
    logic [WORD_BITS-1:0] word;
    logic [4:0]           n_dig;
    logic [4:0]           len;
    logic [4:0]           idx;
    logic [4:0]           dig_ext;
    logic [3:0]           nib_pos;
    logic [3:0]           nib;
    logic [RAM_BYTE-1:0]  char_sel;

    assign dig_ext = (digits == 4'd0) ? 5'(HEX_DIGITS) : {1'b0, digits};

    // Character for idx: prefix, then nibbles n-1..0, anything past the digits is the newline.
    always_comb begin
        nib_pos  = 4'(n_dig - 5'd1 - (idx - PRE_LEN));
        nib      = 4'(word >> {nib_pos, 2'b00});
        char_sel = ASCII_NL;
        if (PREFIX != 0 && idx == 5'd0)
            char_sel = ASCII_0;
        else if (PREFIX != 0 && idx == 5'd1)
            char_sel = ASCII_x;
        else if (idx < PRE_LEN + n_dig)
            char_sel = nibble_to_ascii(nib, UPPER != 0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            push_back <= 1'b0;
            data_out  <= '0;
            word      <= '0;
            n_dig     <= '0;
            len       <= '0;
            idx       <= '0;
        end else begin
            done      <= 1'b0;
            push_back <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        word  <= value;
                        n_dig <= dig_ext;
                        len   <= PRE_LEN + dig_ext + NL_LEN;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= EMIT;
                    end
                end
                EMIT: begin
                    if (!full) begin
                        push_back <= 1'b1;
                        data_out  <= char_sel;
                        state     <= GAP;
                    end
                end
                GAP: begin
                    if (idx == len - 5'd1) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        idx   <= idx + 5'd1;
                        state <= EMIT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
